clock_strobe_monitor: RTL

CLOCK_STROBE_MONITOR -- requirements
Module: clock_strobe_monitor

---
 rtl/clock_strobe_monitor.sv | 129 ++++++++++++
 1 files changed

// File: rtl/clock_strobe_monitor.sv
// Rising-edge strobe, period measurement and loss detection for a slow clock sampled on clock.
// Define CLOCK_STROBE_MONITOR_FALL_EN to add the falling-edge strobe and high-time measurement.
module clock_strobe_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int PERIOD_W    = 16,
  parameter int TIMEOUT     = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clk_in,
  input  logic                enable,
  output logic                strobe,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
`ifdef CLOCK_STROBE_MONITOR_FALL_EN
  output logic                strobe_fall,
  output logic [PERIOD_W-1:0] high_time,
`endif
  output logic                lost
);

  // state   | meaning
  // IDLE    | monitor disabled, outputs cleared, period held
  // ACQUIRE | waiting for the first rising edge
  // LOCKED  | counting cycles between rising edges
  // LOST    | no edge for TIMEOUT cycles, waiting for clk_in to return
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, LOST} state_t;

  localparam logic [PERIOD_W-1:0] CNT_MAX   = '1;
  localparam logic [PERIOD_W-1:0] TIMEOUT_V = PERIOD_W'(TIMEOUT);

  state_t                   state;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     hist;
  logic                     rise;
  logic [PERIOD_W-1:0]      counter;
  logic [PERIOD_W-1:0]      next_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      hist   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
      hist   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise     = sync_q[SYNC_STAGES-1] & ~hist;
  assign next_cnt = (counter == CNT_MAX) ? counter : counter + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      counter      <= '0;
      strobe       <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      lost         <= 1'b0;
    end else if (!enable) begin
      state        <= IDLE;
      counter      <= '0;
      strobe       <= 1'b0;
      period_valid <= 1'b0;
      lost         <= 1'b0;
    end else begin
      strobe <= rise && (state != IDLE);
      case (state)
        IDLE: state <= ACQUIRE;
        ACQUIRE: begin
          if (rise) begin
            state   <= LOCKED;
            counter <= '0;
          end
        end
        LOCKED: begin
          // An edge on the timeout cycle still counts as a valid period.
          if (rise) begin
            period       <= counter + 1'b1;
            period_valid <= 1'b1;
            counter      <= '0;
          end else begin
            counter <= next_cnt;
            if (next_cnt == TIMEOUT_V) begin
              state <= LOST;
              lost  <= 1'b1;
            end
          end
        end
        LOST: begin
          if (rise) begin
            state        <= LOCKED;
            lost         <= 1'b0;
            period_valid <= 1'b0;
            counter      <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CLOCK_STROBE_MONITOR_FALL_EN
  logic                fall;
  logic [PERIOD_W-1:0] high_cnt;

  assign fall = ~sync_q[SYNC_STAGES-1] & hist;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      strobe_fall <= 1'b0;
      high_cnt    <= '0;
      high_time   <= '0;
    end else if (!enable || state == IDLE) begin
      strobe_fall <= 1'b0;
      high_cnt    <= '0;
    end else begin
      strobe_fall <= fall;
      if (rise)
        high_cnt <= '0;
      else if (high_cnt != CNT_MAX)
        high_cnt <= high_cnt + 1'b1;
      if (fall)
        high_time <= high_cnt + 1'b1;
    end
  end
`endif

endmodule
